// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: 8-way round-robin arbiter producing the registered 3-bit select for a 3-to-8 decoder.
// Optional grant hold timeout is compiled in when RR_SEL_TIMEOUT_EN is defined.
module rr_sel_arbiter #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;
  logic             r_busy;
  logic [IDX_W:0]   w_pick;
  logic             w_timeout;
  logic             w_grant_end;

  // Circular first-set search starting at ptr; MSB of the result flags "found".
  // Scanning from the farthest offset down lets the nearest hit win.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = {(IDX_W+1){1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef RR_SEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] r_hold_cnt;

  // Hold counter: zero on the first GRANT cycle, counts every further GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_GRANT) && !w_grant_end) begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end else begin
      r_hold_cnt <= {CNT_W{1'b0}};
    end
  end

  assign w_timeout = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-grant candidate and grant-end detection.
  always_comb begin
    w_pick = rr_pick(i_req, r_ptr);
    if (r_state == ST_GRANT) begin
      w_grant_end = i_release | ~i_req[r_grant_idx] | w_timeout;
    end else begin
      w_grant_end = 1'b0;
    end
  end

  // Arbiter FSM; any grant end returns to IDLE, forcing one idle cycle between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= {IDX_W{1'b0}};
      r_grant_idx   <= {IDX_W{1'b0}};
      r_grant_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_en && w_pick[IDX_W]) begin
            r_state       <= ST_GRANT;
            r_grant_idx   <= w_pick[IDX_W-1:0];
            r_grant_valid <= 1'b1;
            r_busy        <= 1'b1;
          end else begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_grant_end) begin
            r_state       <= ST_IDLE;
            r_ptr         <= r_grant_idx + IDX_W'(1);
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
          end else begin
            r_state       <= ST_GRANT;
            r_grant_valid <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_idx   = r_grant_idx;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: scoreboard bench for rr_sel_arbiter with directed and random stimulus.
// Honors RR_SEL_TIMEOUT_EN to select the expected timeout behaviour.
module tb_rr_sel_arbiter;

  localparam int MAX_HOLD = 16;
`ifdef RR_SEL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic [7:0] i_req = 8'h00;
  logic       i_release = 1'b0;
  logic       o_grant_valid;
  logic [2:0] o_grant_idx;
  logic       o_busy;

  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  // Reference model: owner index or -1, rotating start pointer, cycles held so far.
  int m_ptr = 0;
  int m_owner = -1;
  int m_idx = 0;
  int m_hold = 0;

  rr_sel_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_req(i_req), .i_release(i_release),
    .o_grant_valid(o_grant_valid), .o_grant_idx(o_grant_idx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_idx = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r, input logic rl);
    int c;
    if (m_owner < 0) begin
      if (e && (r != 8'h00)) begin
        for (int k = 0; k < 8; k++) begin
          c = (m_ptr + k) % 8;
          if (r[c] && (m_owner < 0)) begin
            m_owner = c; m_idx = c; m_hold = 1;
          end
        end
      end
    end else if (rl || !r[m_owner] || (TO_EN && (m_hold >= MAX_HOLD))) begin
      m_ptr = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
      m_hold++;
    end
  endtask

  // One clock: apply inputs, let the edge happen, record the expected outputs.
  task automatic cyc(input logic e, input logic [7:0] r, input logic rl);
    exp_t x;
    i_en = e; i_req = r; i_release = rl;
    @(posedge clk);
    model_step(e, r, rl);
    x.v = (m_owner >= 0);
    x.idx = 3'(m_idx);
    exp_q.push_back(x);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    i_en = 1'b0; i_req = 8'h00; i_release = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #20;
    rst_n = 1'b1;
  endtask

  // Monitor: every output cycle is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_valid", int'(o_grant_valid), int'(e.v));
        chk("sb_busy", int'(o_busy), int'(e.v));
        chk("sb_idx", int'(o_grant_idx), int'(e.idx));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bit stopped;
    logic [7:0] r;
    logic e, rl;

    #2;
    chk("rst_valid", int'(o_grant_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_idx", int'(o_grant_idx), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Grant on idx 4, then asynchronous reset mid-cycle.
    cyc(1'b1, 8'h10, 1'b0);
    chk("grant4", int'(o_grant_idx), 4);
    cyc(1'b1, 8'h10, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", int'(o_grant_valid), 0);
    chk("async_rst_idx", int'(o_grant_idx), 0);
    #10;
    rst_n = 1'b1;
    cyc(1'b1, 8'h10, 1'b0);
    chk("post_rst_valid", int'(o_grant_valid), 1);
    chk("post_rst_idx", int'(o_grant_idx), 4);
    cyc(1'b1, 8'h10, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Single request on idx 5, then wrap from ptr 6 to idx 0.
    cyc(1'b1, 8'h20, 1'b0);
    chk("single_idx5", int'(o_grant_idx), 5);
    cyc(1'b1, 8'h20, 1'b1);
    chk("single_end", int'(o_grant_valid), 0);
    cyc(1'b1, 8'h21, 1'b0);
    chk("wrap_idx0", int'(o_grant_idx), 0);
    cyc(1'b0, 8'h21, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Full rotation from ptr 0.
    do_reset();
    for (int g = 0; g < 9; g++) begin
      cyc(1'b1, 8'hFF, 1'b0);
      chk("rot_idx", int'(o_grant_idx), g % 8);
      cyc(1'b1, 8'hFF, 1'b0);
      cyc(1'b1, 8'hFF, 1'b1);
      chk("rot_gap", int'(o_grant_valid), 0);
    end

    // Request drop and enable gating.
    cyc(1'b1, 8'h08, 1'b0);
    chk("drop_idx3", int'(o_grant_idx), 3);
    cyc(1'b1, 8'h00, 1'b0);
    chk("drop_end", int'(o_grant_valid), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'hFF, 1'b0);
      chk("en_low", int'(o_grant_valid), 0);
    end
    cyc(1'b1, 8'hFF, 1'b0);
    chk("en_idx4", int'(o_grant_idx), 4);
    cyc(1'b1, 8'hFF, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Hold timeout (or its absence) on idx 2.
    cyc(1'b1, 8'h0C, 1'b0);
    chk("to_idx2", int'(o_grant_idx), 2);
    run = 1;
    stopped = 1'b0;
    for (int i = 0; i < 119; i++) begin
      cyc(1'b1, 8'h0C, 1'b0);
      if (!stopped && o_grant_valid && (o_grant_idx == 3'd2)) run++;
      else stopped = 1'b1;
    end
    chk("to_hold_len", run, TO_EN ? MAX_HOLD : 120);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Release and request drop together on idx 7.
    cyc(1'b1, 8'h80, 1'b0);
    chk("sim_idx7", int'(o_grant_idx), 7);
    cyc(1'b1, 8'h00, 1'b1);
    chk("sim_end", int'(o_grant_valid), 0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("sim_next0", int'(o_grant_idx), 0);
    cyc(1'b1, 8'hFF, 1'b1);

    // Random traffic; the owner usually keeps its request up.
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom & $urandom);
      if ((m_owner >= 0) && ($urandom_range(0, 3) != 0)) r[m_owner] = 1'b1;
      e = ($urandom_range(0, 9) < 8);
      rl = ($urandom_range(0, 4) == 0);
      cyc(e, r, rl);
    end

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
